// File: rtl/opll_write_scheduler.sv
// Serialising write scheduler: queues CPU register writes and replays them to up to
// three FM chips, holding off each chip until its address/data recovery time has elapsed.
module opll_write_scheduler #(
  parameter int unsigned NUM_CHIPS  = 3,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_WAIT  = 12,
  parameter int unsigned DATA_WAIT  = 84
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic [2:0] chip_en,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_chip,
  input  logic       req_a0,
  input  logic [7:0] req_data,
  output logic [2:0] opl_cs_n,
  output logic       opl_wr_n,
  output logic       opl_a0,
  output logic [7:0] opl_din,
  output logic [3:0] fifo_level,
  output logic       busy,
  output logic       overflow,
  output logic       dropped,
  input  logic       clear_flags
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned MAXW   = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int unsigned WAIT_W = $clog2(MAXW + 1);

  typedef struct packed {
    logic [1:0] chip;
    logic       a0;
    logic [7:0] data;
  } entry_t;

  typedef enum logic {IDLE, STROBE} state_t;

  entry_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [WAIT_W-1:0] wait_cnt [NUM_CHIPS];
  state_t            state;
  logic [1:0]        cur_chip;

  entry_t head;
  logic   push, pop, drop, head_ok, head_clear, any_wait;

  assign head = mem[rd_ptr];

  // Resolve head target: enabled/in-range chip and whether its recovery time is over
  always_comb begin
    head_ok    = 1'b0;
    head_clear = 1'b0;
    any_wait   = 1'b0;
    for (int i = 0; i < int'(NUM_CHIPS); i++) begin
      if (head.chip == 2'(i)) begin
        head_ok    = chip_en[i];
        head_clear = (wait_cnt[i] == WAIT_W'(0));
      end
      if (wait_cnt[i] != WAIT_W'(0)) any_wait = 1'b1;
    end
  end

  assign req_ready  = (level != LVL_W'(FIFO_DEPTH));
  assign push       = req_valid && req_ready;
  assign pop        = (state == IDLE) && (level != LVL_W'(0)) && (!head_ok || head_clear);
  assign drop       = pop && !head_ok;
  assign busy       = (level != LVL_W'(0)) || (state == STROBE) || any_wait;
  assign fifo_level = 4'(level);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{chip: req_chip, a0: req_a0, data: req_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Per-chip recovery counters; the end-of-strobe load wins over the decrement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CHIPS); i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CHIPS); i++) begin
        if (state == STROBE && clk_en && cur_chip == 2'(i))
          wait_cnt[i] <= opl_a0 ? WAIT_W'(DATA_WAIT) : WAIT_W'(ADDR_WAIT);
        else if (clk_en && wait_cnt[i] != WAIT_W'(0))
          wait_cnt[i] <= wait_cnt[i] - WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cur_chip <= '0;
      opl_cs_n <= 3'b111;
      opl_wr_n <= 1'b1;
      opl_a0   <= 1'b0;
      opl_din  <= '0;
      overflow <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop && head_ok) begin
            state    <= STROBE;
            cur_chip <= head.chip;
            opl_a0   <= head.a0;
            opl_din  <= head.data;
            opl_cs_n <= ~(3'b001 << head.chip);
            opl_wr_n <= 1'b0;
          end
        end
        STROBE: begin
          if (clk_en) begin
            state    <= IDLE;
            opl_cs_n <= 3'b111;
            opl_wr_n <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (clear_flags)                 overflow <= 1'b0;
      else if (req_valid && !req_ready) overflow <= 1'b1;

      if (clear_flags) dropped <= 1'b0;
      else if (drop)   dropped <= 1'b1;
    end
  end

endmodule

// File: doc/opll_write_scheduler.md
Name: opll_write_scheduler

Overview:
- Serialising write scheduler for up to 3 jt2413 FM instances sharing one CPU-side write port.
- Buffers CPU register writes (address/data) in a FIFO and replays them to the addressed chip.
- Enforces the YM2413 minimum recovery time after each address write and each data write, so software may issue back-to-back OUTs without wait loops.
- Sits between the IO decoder / CPU bus and the FM instances; owns their cs_n/wr_n/addr/din.

Parameters:
- NUM_CHIPS, 3, number of FM instances served (1..3).
- FIFO_DEPTH, 8, write-queue entries (power of 2, >=2).
- ADDR_WAIT, 12, clk_en ticks of recovery after an address write.
- DATA_WAIT, 84, clk_en ticks of recovery after a data write.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_en  in  1  chip clock enable; same enable that drives the FM instances' cen.
- chip_en  in  3  per-chip enable; bit i low means writes to chip i are discarded.
- req_valid  in  1  CPU write request.
- req_ready  out  1  queue can accept.
- req_chip  in  2  target chip index.
- req_a0  in  1  0 = address register, 1 = data register.
- req_data  in  8  write byte.
- opl_cs_n  out  3  per-chip chip select, active low.
- opl_wr_n  out  1  shared write strobe, active low.
- opl_a0  out  1  shared register select.
- opl_din  out  8  shared data bus.
- fifo_level  out  4  current entry count (0..FIFO_DEPTH).
- busy  out  1  FIFO non-empty, strobe in progress, or any wait counter non-zero.
- overflow  out  1  sticky: req_valid seen while req_ready low.
- dropped  out  1  sticky: an entry was discarded (disabled chip or index >= NUM_CHIPS).
- clear_flags  in  1  synchronous clear of overflow and dropped.

Behaviour:
- Reset values:
  - FIFO empty; req_ready=1.
  - opl_cs_n=3'b111, opl_wr_n=1, opl_a0=0, opl_din=0.
  - fifo_level=0, busy=0, overflow=0, dropped=0.
  - All wait counters 0; FSM in IDLE.
- Push: entry {chip, a0, data} is written when req_valid && req_ready.
- req_ready = (level != FIFO_DEPTH). It is registered-state derived and does not consider a same-cycle pop, so there is no push when full.
- overflow: set on any cycle with req_valid && !req_ready. clear_flags has priority over a same-cycle set.
- Per-chip wait counter:
  - Decrements by 1 on clk_en while non-zero.
  - Saturates at 0; independent per chip.
- FSM state IDLE (FIFO non-empty), evaluating the head entry in priority order:
  - Head chip >= NUM_CHIPS or chip_en[chip]=0: pop, set dropped, stay IDLE (one entry per cycle).
  - Else if wait[chip]==0: pop, latch the entry into the output register, go to STROBE.
  - Else: stall. The head blocks the queue in strict order; there is no reordering.
- FSM state STROBE:
  - opl_cs_n[chip]=0, opl_wr_n=0; opl_a0 and opl_din hold the latched values.
  - Remain until a cycle with clk_en=1. That cycle is the sampling cycle.
  - On the next clk edge: cs_n and wr_n return high, wait[chip] is loaded with ADDR_WAIT (a0=0) or DATA_WAIT (a0=1), and the FSM goes to IDLE.
  - The load has priority over the decrement in that cycle.
- Latency:
  - Push to cs_n low: 2 clk minimum (FIFO write, then IDLE pop).
  - Strobe width: 1..N clk, ending on the first clk_en.
  - At most one chip is strobed at a time. Other chips' counters keep running, so a write to a different chip may issue immediately after a strobe.
- opl_a0/opl_din keep their last value in IDLE. opl_din is only meaningful while cs_n is low.
- chip_en dropping during STROBE: the strobe completes normally.
- Simultaneous push and pop: both occur and level is unchanged; the pointers wrap modulo FIFO_DEPTH.
- Asynchronous reset mid-STROBE: outputs go inactive immediately, and the queue and counters are cleared.
- fifo_level width: clog2(FIFO_DEPTH)+1, presented zero-extended on the 4-bit port.

Test Plan:
1. clk_en every 4th clk; push chip0 a0=0 0x10, then a0=1 0x55. Required:
   - First strobe with din=0x10, wr_n low ending on a clk_en cycle.
   - Second strobe exactly 12 clk_en ticks after the first sampling tick, din=0x55.
   - busy deasserts 84 clk_en ticks after the second sampling tick.
2. Push chip0 data, then chip1 address, back-to-back. Required:
   - chip1 strobes immediately after chip0 (no wait), its cs_n[1] low only.
   - A third write to chip0 waits the full 84 ticks.
3. Fill 8 entries to a stalled chip and assert req_valid once more. Required: req_ready=0, fifo_level=8, overflow=1 and sticky until clear_flags.
4. Set chip_en=3'b101 and push a write to chip1 then chip2. Required: the chip1 entry is dropped, dropped=1, no cs_n[1] activity, and chip2 is written next cycle.
5. With NUM_CHIPS=2, push req_chip=2. Required: the entry is dropped and dropped=1.
6. Assert reset while in STROBE with 3 queued entries. Required: same-cycle cs_n=111, wr_n=1, fifo_level=0, and no strobe after release until new pushes.
